// File: rtl/mult_pkg.sv
// Shared encodings for the sequential 8x8 multiplier control path: FSM
// state codes, nibble-pair selects and shifter amounts.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LSB  = 3'd1,
    ST_MID  = 3'd2,
    ST_MSB  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // {a_sel, b_sel}: 0 = low nibble, 1 = high nibble
  localparam logic [1:0] SEL_LL = 2'b00;
  localparam logic [1:0] SEL_HL = 2'b01;
  localparam logic [1:0] SEL_LH = 2'b10;
  localparam logic [1:0] SEL_HH = 2'b11;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM for the sequential 8x8 multiplier: walks the four 4x4 partial
// products through the nibble mux, shifter and accumulator, one per cycle.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int CNT_W            = 2,
  parameter bit RESTART_ON_START = 1'b1
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [1:0]       input_sel,
  output logic [1:0]       shift_sel,
  output logic             clk_ena,
  output logic             sclr_n,
  output logic             done_flag,
  output logic             err_flag,
  output logic [2:0]       state_out
);

  if (CNT_W != 2) begin : g_bad_cnt_w
    $error("mult_ctrl: CNT_W must be 2");
  end

  state_e state_q, state_d;
  logic   legal_state;
  logic   restart;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    input_sel = SEL_LL;
    shift_sel = SH0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    done_flag = (state_q == ST_DONE);
    err_flag  = (state_q == ST_ERR);
    state_out = state_q;

    legal_state = (state_q inside {ST_IDLE, ST_LSB, ST_MID, ST_MSB, ST_DONE, ST_ERR});
    restart     = start && legal_state &&
                  (RESTART_ON_START || !(state_q inside {ST_MID, ST_MSB}));

    if (restart) begin
      clk_ena = 1'b1;
      sclr_n  = 1'b0;
      state_d = ST_LSB;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: state_d = state_q;
        ST_LSB: begin
          if (count == CNT_W'(0)) begin
            input_sel = SEL_LL;
            shift_sel = SH0;
            clk_ena   = 1'b1;
            state_d   = ST_MID;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_MID: begin
          if (count == CNT_W'(1)) begin
            input_sel = SEL_HL;
            shift_sel = SH4;
            clk_ena   = 1'b1;
          end else if (count == CNT_W'(2)) begin
            input_sel = SEL_LH;
            shift_sel = SH4;
            clk_ena   = 1'b1;
            state_d   = ST_MSB;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_MSB: begin
          if (count == CNT_W'(3)) begin
            input_sel = SEL_HH;
            shift_sel = SH8;
            clk_ena   = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Mealy outputs must read as idle while reset is asserted, even if start is high.
    if (!aclr_n) begin
      input_sel = SEL_LL;
      shift_sel = SH0;
      clk_ena   = 1'b0;
      sclr_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: one instance per restart policy, plus a
// behavioural nibble-mux/shifter/accumulator for end-to-end products.
module tb_mult_ctrl;

  logic       clk;
  logic       aclr_n;
  logic       start;
  logic [1:0] count;

  logic [1:0] isel_r, ssel_r, isel_n, ssel_n;
  logic       ena_r, sclr_r, done_r, err_r, ena_n, sclr_n_n, done_n, err_n;
  logic [2:0] st_r, st_n;

  int tests  = 0;
  int errors = 0;

  mult_ctrl #(.CNT_W(2), .RESTART_ON_START(1'b1)) dut_r (
    .clk(clk), .aclr_n(aclr_n), .start(start), .count(count),
    .input_sel(isel_r), .shift_sel(ssel_r), .clk_ena(ena_r), .sclr_n(sclr_r),
    .done_flag(done_r), .err_flag(err_r), .state_out(st_r)
  );

  mult_ctrl #(.CNT_W(2), .RESTART_ON_START(1'b0)) dut_n (
    .clk(clk), .aclr_n(aclr_n), .start(start), .count(count),
    .input_sel(isel_n), .shift_sel(ssel_n), .clk_ena(ena_n), .sclr_n(sclr_n_n),
    .done_flag(done_n), .err_flag(err_n), .state_out(st_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath driven by dut_r: 4x4 multiplier on selected nibbles, shifter, accumulator.
  logic [7:0]  a_in, b_in;
  logic [15:0] acc;
  logic [3:0]  a_nib, b_nib;
  logic [7:0]  pp8;
  logic [15:0] pp;

  always_comb begin
    a_nib = isel_r[1] ? a_in[7:4] : a_in[3:0];
    b_nib = isel_r[0] ? b_in[7:4] : b_in[3:0];
    pp8   = a_nib * b_nib;
    case (ssel_r)
      2'b01:   pp = {4'h0, pp8, 4'h0};
      2'b10:   pp = {pp8, 8'h00};
      default: pp = {8'h00, pp8};
    endcase
  end

  always @(posedge clk) begin
    if (ena_r) acc <= sclr_r ? acc + pp : 16'h0000;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] c);
    start = s;
    count = c;
    #1;
  endtask

  // Full multiply on both instances: start high for two cycles, then count 0..3.
  task automatic run_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod);
    a_in = a;
    b_in = b;
    drive(1'b1, 2'd0);
    check({tag, " clr sclr_n"}, 16'(sclr_r), 16'd0);
    check({tag, " clr ena"},    16'(ena_r),  16'd1);
    tick();
    check({tag, " arm state"},  16'(st_r),   16'd1);
    check({tag, " arm sclr_n"}, 16'(sclr_r), 16'd0);
    tick();
    drive(1'b0, 2'd0);
    check({tag, " s0 sel"},  16'({isel_r, ssel_r}), 16'b0000);
    check({tag, " s0 ena"},  16'({ena_r, sclr_r}),  16'b11);
    tick();
    check({tag, " s1 state"}, 16'(st_r), 16'd2);
    drive(1'b0, 2'd1);
    check({tag, " s1 sel"},  16'({isel_r, ssel_r}), 16'b0101);
    check({tag, " s1 ena"},  16'(ena_r), 16'd1);
    tick();
    drive(1'b0, 2'd2);
    check({tag, " s2 sel"},  16'({isel_r, ssel_r}), 16'b1001);
    tick();
    check({tag, " s3 state"}, 16'(st_r), 16'd3);
    check({tag, " s3 done"},  16'(done_r), 16'd0);
    drive(1'b0, 2'd3);
    check({tag, " s3 sel"},  16'({isel_r, ssel_r}), 16'b1110);
    tick();
    check({tag, " done r"},  16'({done_r, err_r, st_r}), 16'b10100);
    check({tag, " done n"},  16'({done_n, st_n}), 16'b1100);
    check({tag, " product"}, acc, prod);
  endtask

  initial begin
    aclr_n = 1'b0;
    start  = 1'b0;
    count  = 2'd0;
    a_in   = 8'h00;
    b_in   = 8'h00;
    #2;
    check("por state", 16'(st_r), 16'd0);
    check("por outs",  16'({ena_r, sclr_r, done_r, err_r}), 16'b0100);
    start = 1'b1;
    #1;
    check("rst gates start", 16'({ena_r, sclr_r}), 16'b01);
    start = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    tick();

    run_seq("ff*ff", 8'hFF, 8'hFF, 16'hFE01);

    // Hold in DONE with count wandering.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'(i));
      check("hold", 16'({done_r, ena_r, st_r}), 16'b10100);
      tick();
    end

    run_seq("3c*a5 from done", 8'h3C, 8'hA5, 16'h26AC);

    // Misalignment: count=2 while in LSB.
    drive(1'b1, 2'd0);
    tick();
    drive(1'b0, 2'd2);
    check("misalign ena", 16'(ena_r), 16'd0);
    tick();
    check("err state", 16'({err_r, done_r, ena_r, st_r}), 16'b100101);
    check("err n", 16'(st_n), 16'd5);

    run_seq("12*34 from err", 8'h12, 8'h34, 16'h03A8);

    // Restart in MSB: dut_r restarts, dut_n ignores start and finishes.
    drive(1'b1, 2'd0);
    tick();
    drive(1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd1);
    tick();
    drive(1'b0, 2'd2);
    tick();
    check("pre-restart state", 16'({st_r, st_n}), 16'o33);
    drive(1'b1, 2'd3);
    check("restart r outs", 16'({ena_r, sclr_r}), 16'b10);
    check("restart n outs", 16'({ena_n, sclr_n_n, isel_n, ssel_n}), 16'b111110);
    tick();
    check("restart r state", 16'(st_r), 16'd1);
    check("restart n state", 16'({done_n, st_n}), 16'b1100);
    drive(1'b0, 2'd0);

    // Async reset mid-multiply (MID, count=1 accumulating).
    tick();
    drive(1'b0, 2'd1);
    check("mid ena before rst", 16'(ena_r), 16'd1);
    #2;
    aclr_n = 1'b0;
    #1;
    check("async rst r", 16'({st_r, ena_r, sclr_r, done_r}), 16'b000010);
    check("async rst n", 16'({st_n, done_n}), 16'b0000);
    @(negedge clk);
    aclr_n = 1'b1;
    tick();
    check("idle after rst", 16'(st_r), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control FSM for the sequential 8x8 multiplier. It sits directly downstream of the 2-bit `counter`.
- It consumes `count` each cycle and sequences the four 4x4 partial products through the datapath:
  - nibble-select mux
  - shifter (0/4/8)
  - 16-bit accumulator
- Outputs drive the mux/shifter selects, accumulator enable/clear, done/error flags, and a state code for the 7-segment display.
- Top level holds `counter.aclr_n` low while `start`=1, so `count`=0 in the first cycle after `start` falls.

Parameters:
- CNT_W, 2, width of `count`. Must be 2; the FSM is written for exactly four slices.
- RESTART_ON_START, 1
  - 1: `start`=1 in any state forces restart.
  - 0: `start` is ignored in MID and MSB.

Ports:
- clk  in  1  system clock, rising edge
- aclr_n  in  1  asynchronous active-low reset
- start  in  1  level request; high = clear and arm, falling edge begins multiply
- count  in  CNT_W  slice index from counter
- input_sel  out  2  nibble pair to 4x4 multiplier: {a_sel,b_sel}, 0=low nibble, 1=high nibble
- shift_sel  out  2  shifter amount: 00=<<0, 01=<<4, 10=<<8, 11=unused (treated as <<0)
- clk_ena  out  1  accumulator register enable
- sclr_n  out  1  accumulator synchronous clear, active low
- done_flag  out  1  product valid
- err_flag  out  1  sequence error
- state_out  out  3  state code for display

Behaviour:
- Interface: one clock `clk`. Reset `aclr_n` is asynchronous and active-low.
- State register:
  - 3-bit, updated on `clk` rising edge.
  - `aclr_n`=0 forces IDLE immediately, regardless of clock.
- State codes: IDLE=0, LSB=1, MID=2, MSB=3, DONE=4, ERR=5. Codes 6–7 are illegal and go to IDLE next cycle.
- Output timing:
  - `input_sel`, `shift_sel`, `clk_ena`, `sclr_n` are Mealy: combinational from (state, `count`, `start`).
  - `done_flag`, `err_flag`, `state_out` are Moore: from state only.
- Default output values (every state unless overridden below, and during reset): `input_sel`=00, `shift_sel`=00, `clk_ena`=0, `sclr_n`=1, `done_flag`=0, `err_flag`=0, `state_out`=code of current state.
- `start` priority: `start`=1 overrides everything below. Outputs are `clk_ena`=1, `sclr_n`=0 (accumulator cleared to 0), next state LSB. This applies in:
  - IDLE, LSB, DONE, ERR always;
  - MID and MSB only when RESTART_ON_START=1.
- IDLE: `start`=0 → stay.
- LSB, `start`=0:
  - `count`=0: `input_sel`=00, `shift_sel`=00, `clk_ena`=1; next MID.
  - any other `count`: next ERR, `clk_ena`=0.
- MID, `start`=0:
  - `count`=1: `input_sel`=01, `shift_sel`=01, `clk_ena`=1; stay MID.
  - `count`=2: `input_sel`=10, `shift_sel`=01, `clk_ena`=1; next MSB.
  - `count`=0 or 3: next ERR, `clk_ena`=0.
- MSB, `start`=0:
  - `count`=3: `input_sel`=11, `shift_sel`=10, `clk_ena`=1; next DONE.
  - else: next ERR.
- DONE: `done_flag`=1, `clk_ena`=0; stay until `start`.
- ERR: `err_flag`=1, `clk_ena`=0; stay until `start`.
- Latency: four accumulate cycles after `start` falls; `done_flag` rises on the 4th edge after `start` falls.
- Reset during a multiply: outputs go to default values asynchronously and the accumulator contents are don't-care until the next `start`.

Decomposition:
- Package `mult_pkg`:
  - state enum/localparams (IDLE..ERR, 3-bit);
  - `input_sel` constants (SEL_LL=00, SEL_HL=01, SEL_LH=10, SEL_HH=11);
  - shift constants (SH0, SH4, SH8).
- Single module: state register plus one combinational next-state/output block.
- No sub-module. The display decoder remains separate, outside this block.

Test Plan:
- Reset: `aclr_n`=0 mid-clock → `state_out`=0, `clk_ena`=0, `sclr_n`=1, `done_flag`=0 without waiting for an edge.
- Normal run: `start`=1 for 2 cycles, then 0, with counter stepping 0,1,2,3:
  - `sclr_n`=0 while `start`=1;
  - (`input_sel`,`shift_sel`) = (00,00), (01,01), (10,01), (11,10) on successive cycles;
  - `done_flag`=1 on the 4th edge.
  - End-to-end with datapath: a=0xFF, b=0xFF → product 0xFE01.
- Misalignment: force `count`=2 in LSB with `start`=0 → `state_out`=5, `err_flag`=1, `clk_ena`=0 next cycle.
- Restart: `start`=1 while in MSB:
  - RESTART_ON_START=1 → LSB next edge, `sclr_n`=0 that cycle;
  - RESTART_ON_START=0 → start ignored, reaches DONE.
- Recovery: from ERR and from DONE, pulse `start` → full sequence completes again with `done_flag`=1.
- Hold: after DONE, `start`=0 for 10 cycles → `done_flag` stays 1, `clk_ena` stays 0.
